// File: rtl/frame_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_reader_if
//  Purpose  : Memory read port and pixel stream port of the frame reader.
//  Revision : 1.0 - initial release
// ============================================================================
interface frame_reader_if;
    logic        enable;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sol;
    logic        pix_sof;
    logic        frame_done;

    // master: the frame reader itself; slave: memory plus pixel consumer
    modport master (
        input  enable, mem_gnt, mem_rvalid, mem_rdata, pix_ready,
        output mem_req, mem_addr, pix_valid, pix_data, pix_sol, pix_sof, frame_done
    );

    modport slave (
        output enable, mem_gnt, mem_rvalid, mem_rdata, pix_ready,
        input  mem_req, mem_addr, pix_valid, pix_data, pix_sol, pix_sof, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_reader
//  Purpose  : Scans a frame buffer out of word memory into a tagged pixel stream.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_reader #(
    parameter int          H_PIXELS   = 800,
    parameter int          V_LINES    = 600,
    parameter logic [29:0] FB_BASE    = 30'h04100000,
    parameter int          FIFO_DEPTH = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    frame_reader_if.master bus
);
    localparam int                c_AW       = $clog2(FIFO_DEPTH);
    localparam int                c_CW       = c_AW + 1;
    localparam logic [9:0]        c_X_LAST   = 10'(H_PIXELS - 1);
    localparam logic [9:0]        c_Y_LAST   = 10'(V_LINES - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0]   c_CNT_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW:0]     c_LVL_MAX  = (c_CW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [9:0]      r_req_x, r_req_y;
    logic [9:0]      r_ret_x, r_ret_y;
    logic [c_CW-1:0] r_count, r_outst;
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    // entry: {eof, sof, sol, rgb}
    logic [26:0]     r_fifo [FIFO_DEPTH];

    logic [c_CW:0]   w_level;
    logic            w_req, w_grant, w_push, w_pop, w_valid, w_frame_done;
    logic            w_ret_sol, w_ret_sof, w_ret_eof;
    logic [26:0]     w_head;
    logic            w_unused;

    // Requested plus in-flight words never exceed the FIFO, so a return always has a slot.
    assign w_level   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_req     = (r_state == FETCH) && (w_level < c_LVL_MAX);
    assign w_grant   = w_req & bus.mem_gnt;
    assign w_valid   = (r_count != '0);
    assign w_push    = bus.mem_rvalid & (r_count != c_CNT_FULL);
    assign w_pop     = w_valid & bus.pix_ready;
    assign w_head    = r_fifo[r_rd_ptr];
    assign w_ret_sol = (r_ret_x == 10'd0);
    assign w_ret_sof = w_ret_sol && (r_ret_y == 10'd0);
    assign w_ret_eof = (r_ret_x == c_X_LAST) && (r_ret_y == c_Y_LAST);
    assign w_frame_done = w_pop & w_head[26];
    assign w_unused  = ^bus.mem_rdata[31:24];

    assign bus.mem_req    = w_req;
    assign bus.mem_addr   = FB_BASE + 30'({r_req_y, 10'd0}) + 30'(r_req_x);
    assign bus.pix_valid  = w_valid;
    assign bus.pix_data   = w_valid ? w_head[23:0] : 24'd0;
    assign bus.pix_sol    = w_valid & w_head[24];
    assign bus.pix_sof    = w_valid & w_head[25];
    assign bus.frame_done = w_frame_done;

    // Request side: the last grant wraps the counters so the next frame starts at FB_BASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req_x <= '0;
            r_req_y <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.enable) begin
                        r_state <= FETCH;
                        r_req_x <= '0;
                        r_req_y <= '0;
                    end
                end
                FETCH: begin
                    if (w_grant) begin
                        if (r_req_x == c_X_LAST) begin
                            r_req_x <= '0;
                            if (r_req_y == c_Y_LAST) begin
                                r_req_y <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_req_y <= r_req_y + 10'd1;
                            end
                        end else begin
                            r_req_x <= r_req_x + 10'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_frame_done) begin
                        r_state <= bus.enable ? FETCH : IDLE;
                        r_req_x <= '0;
                        r_req_y <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst <= '0;
        end else begin
            unique case ({w_grant, bus.mem_rvalid})
                2'b10:   r_outst <= r_outst + c_CNT_ONE;
                2'b01:   r_outst <= r_outst - c_CNT_ONE;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Return-side position tags each word as it lands, independent of the request counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ret_x <= '0;
            r_ret_y <= '0;
        end else if (w_push) begin
            if (r_ret_x == c_X_LAST) begin
                r_ret_x <= '0;
                r_ret_y <= (r_ret_y == c_Y_LAST) ? 10'd0 : r_ret_y + 10'd1;
            end else begin
                r_ret_x <= r_ret_x + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {w_ret_eof, w_ret_sof, w_ret_sol, bus.mem_rdata[23:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_reader
//  Purpose  : Directed bench for frame_reader (4x2 and 8x4 frames, depth 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_reader;
    localparam logic [29:0] c_BASE  = 30'h04100000;
    localparam int          c_DEPTH = 16;

    typedef struct {
        int          due;
        logic [29:0] addr;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_reader_if if_s ();
    frame_reader_if if_l ();

    frame_reader #(.H_PIXELS(4), .V_LINES(2), .FB_BASE(c_BASE), .FIFO_DEPTH(c_DEPTH))
        u_dut_s (.clk(clk), .rst(rst), .bus(if_s.master));
    frame_reader #(.H_PIXELS(8), .V_LINES(4), .FB_BASE(c_BASE), .FIFO_DEPTH(c_DEPTH))
        u_dut_l (.clk(clk), .rst(rst), .bus(if_l.master));

    logic        sel, en, gnt, rv, rdy;
    logic [31:0] rdata;
    logic        w_req, w_pv, w_sol, w_sof, w_fd;
    logic [29:0] w_addr;
    logic [23:0] w_pd;

    // The unselected instance sees an idle environment.
    assign if_s.enable     = en  & ~sel;
    assign if_s.mem_gnt    = gnt & ~sel;
    assign if_s.mem_rvalid = rv  & ~sel;
    assign if_s.pix_ready  = rdy & ~sel;
    assign if_s.mem_rdata  = rdata;
    assign if_l.enable     = en  & sel;
    assign if_l.mem_gnt    = gnt & sel;
    assign if_l.mem_rvalid = rv  & sel;
    assign if_l.pix_ready  = rdy & sel;
    assign if_l.mem_rdata  = rdata;

    assign w_req  = sel ? if_l.mem_req    : if_s.mem_req;
    assign w_addr = sel ? if_l.mem_addr   : if_s.mem_addr;
    assign w_pv   = sel ? if_l.pix_valid  : if_s.pix_valid;
    assign w_pd   = sel ? if_l.pix_data   : if_s.pix_data;
    assign w_sol  = sel ? if_l.pix_sol    : if_s.pix_sol;
    assign w_sof  = sel ? if_l.pix_sof    : if_s.pix_sof;
    assign w_fd   = sel ? if_l.frame_done : if_s.frame_done;

    int   n_vec = 0, n_err = 0;
    int   cyc, gx, gy, ex, ey, frames, grants, pops, mfifo, mout, req_seen;
    int   first_grant, first_pop, last_pop, last_due;
    int   valid_err, full_err, stab_err, fd_err, hold_err;
    int   gnt_pct, lat_min, lat_max, rdy_pct;
    logic stall_prev, hold_prev;
    logic [29:0] stall_addr;
    logic [25:0] hold_val;
    rsp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int h_pix();
        return sel ? 8 : 4;
    endfunction

    function automatic int v_lin();
        return sel ? 4 : 2;
    endfunction

    function automatic logic [29:0] exp_addr(input int x, input int y);
        return c_BASE + 30'(y) * 30'd1024 + 30'(x);
    endfunction

    function automatic logic [23:0] pixfn(input logic [29:0] a);
        return a[23:0] ^ 24'hC3A55A;
    endfunction

    task automatic reset_models();
        q.delete();
        cyc = 0; gx = 0; gy = 0; ex = 0; ey = 0; frames = 0; grants = 0; pops = 0;
        mfifo = 0; mout = 0; req_seen = 0; first_grant = 0; first_pop = 0; last_pop = 0;
        last_due = 0; valid_err = 0; full_err = 0; stab_err = 0; fd_err = 0; hold_err = 0;
        stall_prev = 1'b0; hold_prev = 1'b0; stall_addr = '0; hold_val = '0;
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_valid_gap"}, 32'(valid_err), 32'd0);
        chk({tag, "_req_over"},  32'(full_err),  32'd0);
        chk({tag, "_addr_hold"}, 32'(stab_err),  32'd0);
        chk({tag, "_stray_done"}, 32'(fd_err),   32'd0);
        chk({tag, "_pix_hold"},  32'(hold_err),  32'd0);
    endtask

    // One cycle: sample at negedge, serve memory and consumer, drive for the next posedge.
    task automatic step();
        logic        v, r, g, pop, last;
        logic [29:0] a;
        int          lat, due;
        rsp_t        head;
        @(negedge clk);
        v = w_pv; r = w_req; a = w_addr;
        if (v != (mfifo > 0)) valid_err++;
        if (r && (mfifo + mout >= c_DEPTH)) full_err++;
        if (r && stall_prev && a != stall_addr) stab_err++;
        if (hold_prev && v && {w_sof, w_sol, w_pd} != hold_val) hold_err++;
        if (r) req_seen++;
        rv = 1'b0; rdata = '0;
        if (q.size() > 0 && q[0].due <= cyc) begin
            head  = q.pop_front();
            rv    = 1'b1;
            rdata = {8'hEE, pixfn(head.addr)};
        end
        g = ($urandom_range(0, 99) < gnt_pct);
        gnt = g;
        if (r && g) begin
            chk("req_addr", 32'(a), 32'(exp_addr(gx, gy)));
            if (grants == 0) first_grant = cyc;
            grants++;
            if (gx == h_pix() - 1) begin
                gx = 0;
                gy = (gy == v_lin() - 1) ? 0 : gy + 1;
            end else gx++;
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q.push_back('{due, a});
            mout++;
        end
        rdy = ($urandom_range(0, 99) < rdy_pct);
        #1;
        pop = v & rdy;
        if (pop) begin
            last = (ex == h_pix() - 1) && (ey == v_lin() - 1);
            chk("pixel", {5'd0, w_fd, w_sof, w_sol, w_pd},
                {5'd0, last, (ex == 0 && ey == 0), (ex == 0), pixfn(exp_addr(ex, ey))});
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
            if (ex == h_pix() - 1) begin
                ex = 0;
                if (ey == v_lin() - 1) begin
                    ey = 0;
                    frames++;
                end else ey++;
            end else ex++;
        end else if (w_fd) fd_err++;
        if (rv) begin mfifo++; mout--; end
        if (pop) mfifo--;
        stall_prev = r & ~g;
        stall_addr = a;
        hold_prev  = v & ~rdy;
        hold_val   = {w_sof, w_sol, w_pd};
        cyc++;
    endtask

    task automatic run_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames < target && n < budget) begin
            step();
            n++;
        end
        chk("frames_done", 32'(frames), 32'(target));
    endtask

    task automatic pulse_enable();
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    task automatic set_env(input int gp, input int lmin, input int lmax, input int rp);
        gnt_pct = gp; lat_min = lmin; lat_max = lmax; rdy_pct = rp;
    endtask

    initial begin
        int snap, n;
        sel = 1'b0; en = 1'b0; gnt = 1'b0; rv = 1'b0; rdy = 1'b0; rdata = '0;
        reset_models();
        set_env(100, 1, 1, 100);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   32'(w_req),  32'd0);
        chk("rst_addr",  32'(w_addr), 32'(c_BASE));
        chk("rst_valid", 32'(w_pv),   32'd0);
        chk("rst_data",  32'(w_pd),   32'd0);
        chk("rst_tags",  32'({w_fd, w_sof, w_sol}), 32'd0);
        rst = 1'b0;
        repeat (4) step();
        chk("idle_no_req", 32'(req_seen), 32'd0);

        // 4x2 frame, full-rate memory and consumer, single enable pulse
        reset_models();
        pulse_enable();
        run_frames(1, 60);
        chk("f1_grants", 32'(grants), 32'd8);
        chk("f1_first_latency", 32'(first_pop - first_grant), 32'd2);
        chk("f1_burst", 32'(last_pop - first_pop), 32'd7);
        repeat (4) step();
        chk("f1_req_cycles", 32'(req_seen), 32'd8);
        check_errs("f1");

        // random grant stalls, latency 1..5, random consumer stalls
        reset_models();
        set_env(60, 1, 5, 70);
        pulse_enable();
        run_frames(1, 400);
        chk("rnd_grants", 32'(grants), 32'd8);
        check_errs("rnd");

        // enable held for two frames, then dropped part way into the third
        reset_models();
        set_env(80, 1, 3, 80);
        en = 1'b1;
        run_frames(2, 400);
        repeat (2) step();
        en = 1'b0;
        run_frames(3, 400);
        snap = req_seen;
        repeat (6) step();
        chk("drop_no_req", 32'(req_seen - snap), 32'd0);
        chk("drop_grants", 32'(grants), 32'd24);
        check_errs("drop");

        // 8x4 frame, consumer stalled for 40 cycles
        sel = 1'b1;
        reset_models();
        set_env(100, 1, 1, 0);
        pulse_enable();
        repeat (40) step();
        chk("bp_grants", 32'(grants), 32'd16);
        chk("bp_req_low", 32'(w_req), 32'd0);
        chk("bp_valid", 32'(w_pv), 32'd1);
        rdy_pct = 100;
        run_frames(1, 200);
        chk("bp_pops", 32'(pops), 32'd32);
        chk("bp_burst", 32'(last_pop - first_pop), 32'd31);
        check_errs("bp");

        // reset mid-frame with words in flight and a half-full FIFO
        reset_models();
        set_env(100, 3, 3, 0);
        pulse_enable();
        n = 0;
        while (mfifo < 8 && n < 60) begin
            step();
            n++;
        end
        chk("rr_fifo_half", 32'(mfifo), 32'd8);
        chk("rr_outstanding", 32'(mout), 32'd3);
        rv = 1'b1; rdata = 32'h00ABCDEF; gnt = 1'b0; rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("rr_req",   32'(w_req),  32'd0);
        chk("rr_addr",  32'(w_addr), 32'(c_BASE));
        chk("rr_valid", 32'(w_pv),   32'd0);
        chk("rr_data",  32'(w_pd),   32'd0);
        chk("rr_tags",  32'({w_fd, w_sof, w_sol}), 32'd0);
        repeat (3) @(negedge clk);
        rv = 1'b0; rdata = '0;
        reset_models();
        rst = 1'b0;
        set_env(100, 1, 1, 100);
        repeat (5) step();
        chk("rr_no_req", 32'(req_seen), 32'd0);
        pulse_enable();
        run_frames(1, 200);
        chk("rr_pops", 32'(pops), 32'd32);
        check_errs("rr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
